// File: rtl/proto_frame_tx.sv
// Transmit end of the 4-lane parallel protocol: one 16-bit frame goes out as four
// 4-bit data beats plus one parity beat, each beat BAUD_DIV clocks long.
module proto_frame_tx #(
    parameter int BAUD_DIV = 5,
    parameter int NBEATS   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dir_in,
    input  logic [15:0] frame_data,
    output logic        busy,
    output logic        done,
    output logic        direction_pin,
    output logic        strobe_pin,
    output logic        chk_pin,
    output logic [3:0]  data_out
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [1:0]    BEAT_LAST = 2'(NBEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     baud_cnt, baud_nxt;
    logic [1:0]        beat_cnt, beat_nxt;
    logic [15:0]       frame_q, frame_nxt;
    logic [NBEATS-1:0] par_q, par_nxt;
    logic              dir_nxt;

    logic              busy_nxt;
    logic              done_nxt;
    logic              strobe_nxt;
    logic              chk_nxt;
    logic [3:0]        data_nxt;

    // Handshake: start is a request that is taken only when the block is idle;
    // busy (registered) stays high for the whole frame and there is no queueing.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        beat_nxt  = beat_cnt;
        frame_nxt = frame_q;
        par_nxt   = par_q;
        dir_nxt   = direction_pin;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    beat_nxt  = '0;
                    frame_nxt = frame_data;
                    dir_nxt   = dir_in;
                    for (int k = 0; k < NBEATS; k++) begin
                        par_nxt[k] = ^frame_data[4*k +: 4];
                    end
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    if (beat_cnt == BEAT_LAST) begin
                        state_nxt = CHECK;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_cnt + 2'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            CHECK: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = FIN;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so they are registered
    // yet line up with the state they describe.
    always_comb begin
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        strobe_nxt = 1'b0;
        chk_nxt    = 1'b0;
        data_nxt   = 4'h0;
        case (state_nxt)
            DATA: begin
                busy_nxt   = 1'b1;
                data_nxt   = frame_nxt[{beat_nxt, 2'b00} +: 4];
                strobe_nxt = (baud_nxt == BAUD_LAST);
            end
            CHECK: begin
                busy_nxt   = 1'b1;
                chk_nxt    = 1'b1;
                data_nxt   = par_nxt;
                strobe_nxt = (baud_nxt == BAUD_LAST);
            end
            FIN: begin
                done_nxt = 1'b1;
            end
            default: begin
                data_nxt = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            beat_cnt      <= '0;
            frame_q       <= '0;
            par_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            direction_pin <= 1'b0;
            strobe_pin    <= 1'b0;
            chk_pin       <= 1'b0;
            data_out      <= 4'h0;
        end else begin
            state         <= state_nxt;
            baud_cnt      <= baud_nxt;
            beat_cnt      <= beat_nxt;
            frame_q       <= frame_nxt;
            par_q         <= par_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            direction_pin <= dir_nxt;
            strobe_pin    <= strobe_nxt;
            chk_pin       <= chk_nxt;
            data_out      <= data_nxt;
        end
    end

endmodule

// File: tb/tb_proto_frame_tx.sv
// Directed bench for proto_frame_tx: BAUD_DIV=5 instance for single frames,
// BAUD_DIV=2 instance for back-to-back frames with start held high.
module tb_proto_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, dir_in;
    logic [15:0] frame_data;
    logic        busy, done, direction_pin, strobe_pin, chk_pin;
    logic [3:0]  data_out;

    logic        start2, dir2;
    logic [15:0] frame_data2;
    logic        busy2, done2, direction_pin2, strobe_pin2, chk_pin2;
    logic [3:0]  data_out2;

    logic [8:0]  out1, out2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    proto_frame_tx #(.BAUD_DIV(5), .NBEATS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir_in(dir_in), .frame_data(frame_data),
        .busy(busy), .done(done), .direction_pin(direction_pin),
        .strobe_pin(strobe_pin), .chk_pin(chk_pin), .data_out(data_out)
    );

    proto_frame_tx #(.BAUD_DIV(2), .NBEATS(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .dir_in(dir2), .frame_data(frame_data2),
        .busy(busy2), .done(done2), .direction_pin(direction_pin2),
        .strobe_pin(strobe_pin2), .chk_pin(chk_pin2), .data_out(data_out2)
    );

    assign out1 = {busy, done, direction_pin, strobe_pin, chk_pin, data_out};
    assign out2 = {busy2, done2, direction_pin2, strobe_pin2, chk_pin2, data_out2};

    // beats holds the hand-computed beat nibbles: [3:0] beat 0 ... [19:16] checksum.
    function automatic logic [8:0] expect_out(input logic [19:0] beats, input logic d,
                                              input int b, input int n);
        logic [8:0] e;
        int k;
        if (n >= 1 && n <= 5*b) begin
            k = (n - 1) / b;
            e = {1'b1, 1'b0, d, (n % b == 0), (k == 4), beats[4*k +: 4]};
        end else if (n == 5*b + 1) begin
            e = {1'b0, 1'b1, d, 1'b0, 1'b0, 4'h0};
        end else begin
            e = {2'b00, d, 6'b0};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] fd, input logic d, input logic prev_dir,
                          input string tag);
        check({tag, " idle"}, out1, {2'b00, prev_dir, 6'b0});
        frame_data = fd;
        dir_in     = d;
        start      = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic watch(input string tag, input logic [19:0] beats, input logic d,
                         input int last, input int inj1, input int inj2);
        for (int n = 1; n <= last; n++) begin
            check($sformatf("%s c%0d", tag, n), out1, expect_out(beats, d, 5, n));
            start      = (n == inj1) || (n == inj2);
            frame_data = 16'($urandom);
            dir_in     = ~d;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        dir_in      = 1'b0;
        frame_data  = 16'h0;
        start2      = 1'b0;
        dir2        = 1'b0;
        frame_data2 = 16'h0;
        #1;
        check("reset out1", out1, 9'h000);
        check("reset out2", out2, 9'h000);
        repeat (3) step();
        check("reset held", out1, 9'h000);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("idle c%0d", i), out1, 9'h000);
        end

        accept(16'h1234, 1'b1, 1'b0, "m");
        watch("m", 20'hD1234, 1'b1, 27, 0, 0);

        accept(16'hA5C3, 1'b0, 1'b1, "s");
        watch("s", 20'h0A5C3, 1'b0, 27, 0, 0);

        accept(16'h5A7E, 1'b1, 1'b0, "ign");
        watch("ign", 20'h35A7E, 1'b1, 26, 3, 26);
        accept(16'hC3A5, 1'b0, 1'b1, "nxt");
        watch("nxt", 20'h0C3A5, 1'b0, 27, 0, 0);

        accept(16'h1234, 1'b1, 1'b0, "r");
        watch("r", 20'hD1234, 1'b1, 11, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst async", out1, 9'h000);
        step();
        check("rst hold1", out1, 9'h000);
        step();
        check("rst hold2", out1, 9'h000);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post rst c%0d", i), out1, 9'h000);
        end
        accept(16'h8421, 1'b1, 1'b0, "post");
        watch("post", 20'hF8421, 1'b1, 27, 0, 0);

        dir2        = 1'b1;
        frame_data2 = 16'hBEEF;
        start2      = 1'b1;
        step();
        for (int n = 1; n <= 36; n++) begin
            check($sformatf("cont c%0d", n), out2,
                  expect_out(20'hEBEEF, 1'b1, 2, ((n - 1) % 12) + 1));
            step();
        end
        start2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/proto_frame_tx.md
Name: proto_frame_tx

Overview:
- Transmit end of the team's 4-lane custom parallel protocol.
- Accepts one 16-bit frame from the host and serialises it as four 4-bit data beats followed by one parity (checksum) beat.
- Beats are paced by an internal baud divider; the receive block samples them.
- Each beat is qualified by strobe_pin. direction_pin tells the far end which buffer (master or slave) is being loaded.

Parameters:
- BAUD_DIV, 5, clk cycles per beat; legal range 2..255; counter width is clog2(BAUD_DIV).
- NBEATS, 4, data beats per frame; fixed at 4 by the protocol; the parity vector is NBEATS bits wide.

Ports:
- clk  in  1  system clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  host request; sampled only while busy=0
- dir_in  in  1  frame direction; 1 = master-to-slave; latched on start acceptance
- frame_data  in  16  payload; beat k carries frame_data[4k+3:4k]; latched on start acceptance
- busy  out  1  high from the cycle after acceptance through the last beat
- done  out  1  single-cycle pulse after the checksum beat completes
- direction_pin  out  1  latched dir_in, held stable for the whole frame and after it
- strobe_pin  out  1  one-cycle beat-valid pulse
- chk_pin  out  1  high for the whole checksum beat
- data_out  out  4  lane data

Behaviour:
- Reset (async, immediate, also mid-frame):
  - busy, done, strobe_pin, chk_pin, direction_pin = 0; data_out = 4'h0.
  - State = IDLE; baud counter = 0; beat counter = 0.
  - Any frame in flight is abandoned; no done pulse is issued.
- Registers: all outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, DATA, CHECK, FIN.
- IDLE:
  - data_out = 0, strobe_pin = 0, chk_pin = 0; direction_pin keeps its last value.
  - If start=1, at edge 0 (acceptance): latch frame_data and dir_in, compute parity P, clear the baud and beat counters, go to DATA.
- Parity: P[k] = XOR of the four bits of beat k, for k = 0..3. Bit k of P corresponds to beat k.
- Beat timing, counting the acceptance edge as cycle 0:
  - Beat k (k = 0..4, where 4 is the checksum beat) drives data_out during cycles k*BAUD_DIV+1 through (k+1)*BAUD_DIV.
  - data_out is stable for the whole beat.
  - strobe_pin = 1 only in the final cycle of each beat, cycle (k+1)*BAUD_DIV.
- DATA:
  - data_out = latched beat[beat counter].
  - The baud counter increments each cycle and wraps at BAUD_DIV-1. The wrap cycle is the strobe cycle.
  - After the strobe of beat 3, go to CHECK.
- CHECK:
  - data_out = P; chk_pin = 1 for all BAUD_DIV cycles.
  - Strobe occurs in the last cycle; then go to FIN.
- FIN:
  - Lasts one cycle: busy = 0, done = 1, data_out = 0, chk_pin = 0; then go to IDLE.
  - A start in the FIN cycle is ignored. The earliest new acceptance is in the cycle after FIN.
- busy = 1 in cycles 1 .. 5*BAUD_DIV; done is asserted in cycle 5*BAUD_DIV+1.
- Total frame latency is 5*BAUD_DIV+1 cycles from acceptance to done.
- start while busy=1 is ignored; there is no queueing.
- frame_data and dir_in changes after acceptance have no effect on the frame in flight.
- direction_pin updates at acceptance, so it is already valid in cycle 1, the first beat cycle.
- start held high continuously: frames are sent back-to-back, separated by the FIN cycle plus one IDLE cycle.

Test Plan:
- Reset then idle (rst pulsed, start=0 for 50 cycles) -> all outputs 0 throughout, busy never asserted.
- Master frame (BAUD_DIV=5, frame_data=16'h1234, dir_in=1, start for 1 cycle):
  - data_out = 4, 3, 2, 1 in cycles 1-5, 6-10, 11-15, 16-20.
  - Then 4'hD (P=1101) with chk_pin=1 in cycles 21-25.
  - strobe_pin exactly at cycles 5, 10, 15, 20, 25; done at cycle 26; direction_pin = 1 from cycle 1.
- Slave frame with zero parity (frame_data=16'hA5C3, dir_in=0):
  - Beats are 3, C, 5, A, then checksum 4'h0.
  - direction_pin = 0; exactly 5 strobes; done at cycle 26.
- Ignored inputs:
  - start pulsed at cycles 3 and 26 with a different frame_data -> first frame unchanged, no second frame.
  - Then start at cycle 27 -> new frame accepted, beat 0 at cycle 28.
- Async reset at cycle 12, mid-beat 2 -> all outputs 0 within the same cycle, no done. The next start after reset release sends a complete frame.
- Continuous start with BAUD_DIV=2 -> frames repeat every 12 cycles (10 beat cycles + FIN + IDLE), with strobes on every even beat cycle.
